wt_dcache_wr_port_arbiter: RTL
==============================

// Module: wt_dcache_wr_port_arbiter
// PURPOSE
//  Splits NumPorts LSU D$ request ports into NumPorts read-only ports and NumWrPorts write-only
//  channels of wt_dcache. Writes are arbitrated fixed-priority or round-robin. A channel stays
//  locked to its winner until the cache grants, so a request never changes while waiting.
//  Sits between the LSU ports and wt_dcache inside the write-through cache subsystem.
// PARAMETERS
//  CVA6Cfg     config_pkg::cva6_cfg_empty  core configuration
//  NumPorts    4   LSU request ports (>=2)
//  NumWrPorts  1   write channels into wt_dcache (1..NumPorts)
//  ArbMode     1   0: fixed priority, lowest index wins; 1: round-robin
// PORTS
//  clk_i        in   1                         clock
//  rst_ni       in   1                         async reset, active low
//  req_ports_i  in   dcache_req_t[NumPorts]    LSU requests
//  rsp_ports_o  out  dcache_rsp_t[NumPorts]    LSU responses
//  rd_req_o     out  dcache_req_t[NumPorts]    to cache read ports
//  rd_rsp_i     in   dcache_rsp_t[NumPorts]    from cache read ports
//  wr_req_o     out  dcache_req_t[NumWrPorts]  to cache write channels
//  wr_rsp_i     in   dcache_rsp_t[NumWrPorts]  from cache write channels
//  wr_stall_o   out  NumPorts                  port i has a write pending, not presented this cycle
// BEHAVIOUR
//  - Port i is a write candidate when data_req && data_we. Otherwise rd_req_o[i]=req_ports_i[i].
//    When port i is a write candidate, rd_req_o[i]='0.
//  - rsp_ports_o[i].data_rvalid/rid/rdata/ruser always come from rd_rsp_i[i].
//  - rsp_ports_o[i].data_gnt:
//      - from rd_rsp_i[i] when the port is a read;
//      - from wr_rsp_i[w] when the port is presented on channel w;
//      - 0 otherwise.
//  - State, per channel w: lock_vld_q[w] and lock_idx_q[w] (clog2 NumPorts bits).
//    Global: rr_ptr_q (clog2 NumPorts bits).
//  - Channel w has two states:
//      - IDLE: a candidate is available -> present it. If wr_rsp_i[w].data_gnt is 0 that cycle,
//        go to LOCKED with lock_idx_q=winner. If granted, stay IDLE.
//      - LOCKED: present req_ports_i[lock_idx_q] unchanged. data_gnt -> IDLE.
//        Locked port drops data_req or data_we -> IDLE the same cycle, and wr_req_o[w]='0.
//  - Channels evaluate in ascending w within one cycle.
//      - Locked ports are excluded from IDLE selection.
//      - Each port is assigned to at most one channel.
//  - Selection start point:
//      - ArbMode=1: search starts at rr_ptr_q and wraps modulo NumPorts. Non-power-of-2 NumPorts
//        must wrap correctly.
//      - ArbMode=0: search starts at 0.
//  - rr_ptr_q update, ArbMode=1: on every write grant rr_ptr_q <= (granted idx + 1) mod NumPorts.
//    With multiple grants in one cycle, the highest-w granted channel determines the update.
//  - Unused channel drives wr_req_o[w]='0.
//  - Latency: combinational request path, zero added cycles. State updates on posedge clk_i.
//  - wr_stall_o[i] = write candidate && not presented on any channel (combinational).
//  - Reset (async, rst_ni=0):
//      - lock_vld_q=0, lock_idx_q=0, rr_ptr_q=0.
//      - Outputs follow the combinational rules with no locks: first candidate from index 0.
//  - Reset mid-lock drops the lock; on release arbitration restarts from port 0.
//  - Assertions:
//      - a locked request does not change before data_gnt;
//      - no port is presented on two channels.
// TESTING
//  1. NumWrPorts=1, ArbMode=1, ports 1 and 3 write at once, gnt every cycle.
//     -> grant order 1,3,1,3; rr_ptr_q 2,0,2.
//  2. Port 2 writes, gnt held 0 for 3 cycles while port 0 starts writing.
//     -> wr_req_o[0] stays port 2 all 3 cycles; wr_stall_o=4'b0001;
//        port 0 is presented the cycle after gnt.
//  3. NumWrPorts=2, ports 0,1,2 write.
//     -> ch0=port0, ch1=port1, wr_stall_o[2]=1; both granted -> next cycle ch0=port2.
//  4. Port 1 reads while port 0 writes.
//     -> rd_req_o[1]=req_ports_i[1], rd_req_o[0]='0, port 1 gets rd_rsp_i[1].data_gnt.
//        rvalid/rdata on port 0 are still passed through from rd_rsp_i[0].
//  5. ArbMode=0, ports 0 and 2 write continuously, gnt every cycle.
//     -> port 0 always wins; wr_stall_o[2]=1 every cycle.
//  6. Lock on port 3, rst_ni pulsed low mid-lock. -> lock cleared asynchronously, rr_ptr_q=0.
//     Locked port drops data_req -> channel idle that cycle.

Source files
------------

// File: rtl/wt_dcache_wr_port_arbiter.sv
// Write-port arbiter for the write-through D$.
// Splits NumPorts LSU request ports into read traffic, which passes straight through to the
// cache read ports, and write traffic, which is arbitrated onto NumWrPorts write channels.
// A channel that presents a write without an immediate grant locks onto that port until
// the cache grants, so the request seen by the cache never changes while it waits.
//
// Request/response words are flat vectors. The arbiter only inspects these control bits:
//   request  bit 1 : data_req        response bit 0 : data_gnt
//   request  bit 0 : data_we         response [RspWidth-1:1] : rvalid/rid/rdata/ruser payload
// All other request bits (address, wdata, be, size, id, ...) are forwarded untouched.
module wt_dcache_wr_port_arbiter #(
    parameter int unsigned NumPorts   = 4,   // LSU request ports (>= 2)
    parameter int unsigned NumWrPorts = 1,   // write channels into the cache (1..NumPorts)
    parameter int unsigned ArbMode    = 1,   // 0: fixed priority, 1: round-robin
    parameter int unsigned ReqWidth   = 16,  // request word width (>= 2)
    parameter int unsigned RspWidth   = 16   // response word width (>= 2)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NumPorts-1:0][ReqWidth-1:0]    req_ports_i,
    output logic [NumPorts-1:0][RspWidth-1:0]    rsp_ports_o,
    output logic [NumPorts-1:0][ReqWidth-1:0]    rd_req_o,
    input  logic [NumPorts-1:0][RspWidth-1:0]    rd_rsp_i,
    output logic [NumWrPorts-1:0][ReqWidth-1:0]  wr_req_o,
    input  logic [NumWrPorts-1:0][RspWidth-1:0]  wr_rsp_i,
    output logic [NumPorts-1:0]                  wr_stall_o
);

    localparam int unsigned REQ_BIT = 1;
    localparam int unsigned WE_BIT  = 0;
    localparam int unsigned GNT_BIT = 0;
    localparam int unsigned IdxW    = $clog2(NumPorts);
    localparam int unsigned PosW    = IdxW + 1;

    typedef logic [IdxW-1:0] idx_t;
    typedef logic [PosW-1:0] pos_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } ch_state_t;

    // Per-channel state and global round-robin pointer
    ch_state_t [NumWrPorts-1:0]     state_q;
    ch_state_t [NumWrPorts-1:0]     state_d;
    logic      [NumWrPorts-1:0]     lock_vld_q;
    idx_t      [NumWrPorts-1:0]     lock_idx_q;
    idx_t      [NumWrPorts-1:0]     lock_idx_d;
    idx_t                           rr_ptr_q;
    idx_t                           rr_ptr_d;

    // Combinational arbitration results
    logic      [NumPorts-1:0]       cand;        // port holds a write request
    logic      [NumPorts-1:0]       busy;        // port already claimed this cycle
    logic      [NumPorts-1:0]       presented;   // port is on some channel
    logic      [NumPorts-1:0]       port_wgnt;   // grant returned to that port by its channel
    logic      [NumWrPorts-1:0]     lock_live;   // lock still backed by an active write
    logic      [NumWrPorts-1:0]     ch_present;  // channel drives a request this cycle
    idx_t      [NumWrPorts-1:0]     ch_sel;      // port driven by the channel
    idx_t                           start_idx;
    pos_t                           pos;

    // Write-channel response payload is not routed anywhere: read data comes from rd_rsp_i
    logic                           wr_rsp_unused;
    assign wr_rsp_unused = ^wr_rsp_i;

    genvar gi, gj;

    generate
        for (gi = 0; gi < NumPorts; gi++) begin : g_cand
            assign cand[gi] = req_ports_i[gi][REQ_BIT] & req_ports_i[gi][WE_BIT];
        end
        for (gi = 0; gi < NumWrPorts; gi++) begin : g_lock_vld
            assign lock_vld_q[gi] = (state_q[gi] == LOCKED);
        end
    endgenerate

    // Channel selection (ascending channel order) and next-state computation
    always_comb begin
        busy       = '0;
        lock_live  = '0;
        ch_present = '0;
        ch_sel     = '0;
        pos        = '0;
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;
        start_idx  = (ArbMode == 1) ? rr_ptr_q : '0;

        // Ports held by a live lock on any channel are off limits to idle channels
        for (int w = 0; w < NumWrPorts; w++) begin
            lock_live[w] = lock_vld_q[w] && cand[lock_idx_q[w]];
            if (lock_live[w]) begin
                busy[lock_idx_q[w]] = 1'b1;
            end
        end

        for (int w = 0; w < NumWrPorts; w++) begin
            if (lock_vld_q[w]) begin
                // A locked port that withdrew its write leaves the channel empty this cycle
                ch_present[w] = lock_live[w];
                ch_sel[w]     = lock_idx_q[w];
            end else begin
                for (int j = 0; j < NumPorts; j++) begin
                    pos = {1'b0, start_idx} + PosW'(j);
                    if (pos >= PosW'(NumPorts)) begin
                        pos = pos - PosW'(NumPorts);
                    end
                    if (!ch_present[w] && cand[pos[IdxW-1:0]] && !busy[pos[IdxW-1:0]]) begin
                        ch_present[w] = 1'b1;
                        ch_sel[w]     = pos[IdxW-1:0];
                    end
                end
                if (ch_present[w]) begin
                    busy[ch_sel[w]] = 1'b1;
                end
            end

            if (ch_present[w]) begin
                if (wr_rsp_i[w][GNT_BIT]) begin
                    state_d[w] = IDLE;
                    // Later channels overwrite earlier ones, so the highest granted channel wins
                    if (ArbMode == 1) begin
                        rr_ptr_d = (ch_sel[w] == idx_t'(NumPorts - 1)) ? '0
                                                                       : ch_sel[w] + idx_t'(1);
                    end
                end else begin
                    state_d[w]    = LOCKED;
                    lock_idx_d[w] = ch_sel[w];
                end
            end else begin
                state_d[w] = IDLE;
            end
        end
    end

    // State registers, cleared asynchronously so a reset mid-lock drops the lock at once
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int w = 0; w < NumWrPorts; w++) begin
                state_q[w]    <= IDLE;
                lock_idx_q[w] <= '0;
            end
            rr_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    // Per-port view of the channel assignment: who is presented and what grant they get
    always_comb begin
        presented = '0;
        port_wgnt = '0;
        for (int w = 0; w < NumWrPorts; w++) begin
            if (ch_present[w]) begin
                presented[ch_sel[w]] = 1'b1;
                port_wgnt[ch_sel[w]] = wr_rsp_i[w][GNT_BIT];
            end
        end
    end

    generate
        for (gi = 0; gi < NumPorts; gi++) begin : g_port
            assign rd_req_o[gi]    = cand[gi] ? '0 : req_ports_i[gi];
            assign rsp_ports_o[gi] = {rd_rsp_i[gi][RspWidth-1:1],
                                      cand[gi] ? port_wgnt[gi] : rd_rsp_i[gi][GNT_BIT]};
            assign wr_stall_o[gi]  = cand[gi] & ~presented[gi];
        end

        for (gi = 0; gi < NumWrPorts; gi++) begin : g_ch
            assign wr_req_o[gi] = ch_present[gi] ? req_ports_i[ch_sel[gi]] : '0;

            // The request a channel waits on must not change before it is granted
            a_lock_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
                lock_live[gi] |-> (wr_req_o[gi] == $past(wr_req_o[gi])));

            for (gj = gi + 1; gj < NumWrPorts; gj++) begin : g_pair
                // A port is never presented on two channels at once
                a_one_channel: assert property (@(posedge clk_i) disable iff (!rst_ni)
                    !(ch_present[gi] && ch_present[gj] && (ch_sel[gi] == ch_sel[gj])));
            end
        end
    endgenerate

endmodule
